// File: rtl/reg_write_arbiter_if.sv
// reg_write_arbiter_if: requester-side bus of the shared-register write arbiter.
interface reg_write_arbiter_if #(
    parameter int BITWIDTH = 16,
    parameter int NUM_REQ  = 4
);
    localparam int SW = $clog2(NUM_REQ);
    logic [NUM_REQ-1:0]          req;
    logic [NUM_REQ-1:0]          lock;
    logic [NUM_REQ*BITWIDTH-1:0] data;
    logic [NUM_REQ-1:0]          gnt;
    logic [BITWIDTH-1:0]         q;
    logic [SW-1:0]               q_src;
    logic                        q_valid;
    modport master (output req, lock, data, input gnt, q, q_src, q_valid);
    modport slave (input req, lock, data, output gnt, q, q_src, q_valid);
endinterface

// File: rtl/reg_write_arbiter.sv
// reg_write_arbiter: round-robin writes into one shared register, with
// bounded back-to-back locking by a single owner.
module reg_write_arbiter #(
    parameter int BITWIDTH = 16,
    parameter int NUM_REQ  = 4,
    parameter int LOCK_MAX = 8
) (
    input logic clk,
    input logic rst,
    reg_write_arbiter_if.slave bus
);
    localparam int SW = $clog2(NUM_REQ);

    typedef enum logic {OPEN, LOCKED} state_e;

    state_e              state_q, state_d;
    logic [SW-1:0]       ptr_q, ptr_d;
    logic [SW-1:0]       owner_q, owner_d;
    logic [SW-1:0]       src_q, src_d;
    logic [7:0]          cnt_q, cnt_d;
    logic [BITWIDTH-1:0] data_q, data_d;
    logic                valid_q, valid_d;
    logic [NUM_REQ-1:0]  gnt, others, cand;
    logic [SW-1:0]       start, idx, win;
    logic                owner_keep, found;

    // Owner keeps the register until its budget runs out, unless nobody else waits.
    always_comb begin
        others     = bus.req & ~(NUM_REQ'(1) << owner_q);
        owner_keep = state_q == LOCKED && bus.req[owner_q] &&
                     (cnt_q < 8'(LOCK_MAX) || others == '0);
        start      = state_q == LOCKED ? SW'((int'(owner_q) + 1) % NUM_REQ) : ptr_q;
        cand       = state_q == LOCKED ? others : bus.req;
        found      = owner_keep;
        win        = owner_q;
        idx        = start;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = SW'((int'(start) + k) % NUM_REQ);
            if (!found && cand[idx]) begin
                found = 1'b1;
                win   = idx;
            end
        end
        gnt = (found && !rst) ? NUM_REQ'(1) << win : '0;
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        owner_d = owner_q;
        cnt_d   = cnt_q;
        data_d  = data_q;
        src_d   = src_q;
        valid_d = |gnt;
        if (|gnt) begin
            data_d = bus.data[win*BITWIDTH +: BITWIDTH];
            src_d  = win;
            ptr_d  = SW'((int'(win) + 1) % NUM_REQ);
            if (bus.lock[win]) begin
                state_d = LOCKED;
                owner_d = win;
                cnt_d   = (state_q == LOCKED && owner_q == win) ?
                          (cnt_q < 8'(LOCK_MAX) ? cnt_q + 8'd1 : cnt_q) : 8'd1;
            end else begin
                state_d = OPEN;
                cnt_d   = '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= OPEN;
            ptr_q   <= '0;
            owner_q <= '0;
            cnt_q   <= '0;
            data_q  <= '0;
            src_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            owner_q <= owner_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
            src_q   <= src_d;
            valid_q <= valid_d;
        end
    end

    assign bus.gnt     = gnt;
    assign bus.q       = data_q;
    assign bus.q_src   = src_q;
    assign bus.q_valid = valid_q;
endmodule
